datapath_ctrl: RTL
==================

# datapath_ctrl

Multi-cycle instruction sequencer that sits directly upstream of the register-file/ALU datapath. Accepts one instruction per valid/ready handshake and decodes it into the datapath's control and data inputs (`ra1`, `ra2`, `ULAControl`, `select_src`, `constante`, `wa3`, `wd3`, `we3`). Captures the datapath's `ULAResult`, `Flag_z` and `CarryOut`, and writes the result back into the register file through `wd3`.

## Interface
Parameters:
- `DataWidth`, 8: datapath word width.
- `InstrWidth`, 14+DataWidth: instruction width; derived, do not override.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `instr_valid`  in  1  an instruction is present on `instr`.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `instr`  in  InstrWidth  instruction word.
- `ULAResult`  in  DataWidth  ALU result from the datapath.
- `Flag_z`  in  1  ALU zero flag from the datapath.
- `CarryOut`  in  1  ALU carry from the datapath.
- `ra1`, `ra2`  out  3  register-file read addresses.
- `ULAControl`  out  3  ALU operation select.
- `select_src`  out  1  0 selects `rd2`, 1 selects `constante` as SrcB.
- `constante`  out  DataWidth  immediate operand.
- `wa3`  out  3  write address.
- `wd3`  out  DataWidth  write data.
- `we3`  out  1  register-file write enable.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `result_q`  out  DataWidth  last captured ALU result or loaded immediate.
- `zero_q`, `carry_q`  out  1  flags captured from the last ALU-type instruction.

## Operation
- Instruction fields, with DW = DataWidth:
  - `type` = [13+DW:12+DW]
  - `op` = [11+DW:9+DW]
  - `rd` = [8+DW:6+DW]
  - `ra` = [5+DW:3+DW]
  - `rb` = [2+DW:DW]
  - `imm` = [DW-1:0]
- Types:
  - 00 LOADI: rd <= imm.
  - 01 ALURR: rd <= ra op rb.
  - 10 ALURI: rd <= ra op imm.
  - 11 CMP: ra op rb; flags only, no writeback.
- `op` is passed to `ULAControl` unmodified. The sequencer does not interpret ALU encodings.
- The accepted instruction is latched into an internal register. All datapath-facing outputs are decoded from the state and this register only. There is no combinational path from `instr` to any datapath output.
- FSM states: IDLE, EXEC, WB.
  - IDLE: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch `instr`.
    - LOADI goes to WB.
    - All other types go to EXEC.
  - EXEC (one cycle):
    - `ra1`=ra, `ra2`=rb, `ULAControl`=op.
    - `select_src`=1 and `constante`=imm for ALURI only; otherwise `select_src`=0 and `constante`=0.
    - At the end of the cycle, capture `ULAResult`→`result_q`, `Flag_z`→`zero_q`, `CarryOut`→`carry_q`.
    - CMP then goes to IDLE with `done` pulsed in the following cycle. ALURR/ALURI go to WB.
  - WB (one cycle):
    - `we3`=1, `wa3`=rd.
    - `wd3` = `result_q` for ALU types, or imm for LOADI; LOADI also loads imm into `result_q`.
    - `done`=1. Next state is IDLE.
- LOADI does not modify `zero_q`/`carry_q`.
- In all states other than those above: `we3`=0 and `ra1`/`ra2`/`ULAControl`/`select_src`/`constante` hold 0.
- rd = r0 is written like any other register. No special casing.

## Timing
- Reset (`reset`=0 at an edge): state←IDLE. All outputs are 0, including `result_q`, `zero_q`, `carry_q`, `we3`, `done` and the latched instruction.
  - `instr_ready`=0 while `reset` is low.
  - Reset asserted mid-EXEC or mid-WB aborts the instruction. No `we3` pulse and no `done` occur after the reset edge.
- Latency (handshake at edge t0):
  - ALURR/ALURI: EXEC in cycle t0–t1; WB with `we3`=1 in cycle t1–t2; the register is updated at edge t2; `instr_ready`=1 again from t2.
  - LOADI: WB in cycle t0–t1; `instr_ready` from t1.
  - CMP: EXEC in cycle t0–t1; `done` in cycle t1–t2; `instr_ready` from t1.
- Throughput: LOADI every 2 cycles, ALU types every 3 cycles, CMP every 2 cycles.
- `instr_valid` held with `instr_ready`=0 is ignored; the instruction is not consumed. `instr` may change freely while not accepted.
- No RAW hazard: a write at edge t2 always precedes the next EXEC read cycle.
- `done` is exactly one cycle per retired instruction.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `instr_valid`=1 → all outputs 0, `instr_ready`=0, no `we3`. Release → `instr_ready`=1 on the next cycle.
- LOADI rd=3, imm=0xA5:
  - `we3`=1, `wa3`=3, `wd3`=0xA5 for exactly 1 cycle, one cycle after the handshake.
  - `done` coincident; `result_q`=0xA5; `zero_q`/`carry_q` unchanged.
- ALURR op=3'b010, ra=1, rb=2, with an ALU stub returning `ULAResult`=0x00, `Flag_z`=1, `CarryOut`=1:
  - EXEC shows `ra1`=1, `ra2`=2, `ULAControl`=010, `select_src`=0.
  - Next cycle: `wa3`=rd, `wd3`=0x00, `we3`=1; `zero_q`=1, `carry_q`=1.
- ALURI imm=0x7F → in EXEC, `select_src`=1 and `constante`=0x7F; WB writes the stub result.
- CMP → `zero_q`/`carry_q` update; `we3` never asserts; `done` pulses once; `result_q`=`ULAResult`.
- Back-to-back with `instr_valid` held high: LOADI, ALURR, CMP → handshakes at cycles 0, 2, 5; no instruction dropped or duplicated. Assert `reset`=0 during the ALURR EXEC → no `we3` pulse follows.

Source files
------------

// File: rtl/datapath_ctrl_if.sv
// Instruction handshake bundle between an instruction source and the datapath sequencer.
// The instruction width is always 14 bits of fields plus one datapath word of immediate.
interface datapath_ctrl_if #(
  parameter int DataWidth = 8
);
  localparam int InstrWidth = 14 + DataWidth;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [InstrWidth-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer: latches one instruction per handshake, drives the register-file/ALU
// datapath for EXEC and write-back, and keeps the last result and ALU flags.
module datapath_ctrl #(
  parameter  int DataWidth  = 8,
  localparam int InstrWidth = 14 + DataWidth
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_ctrl_if.slave       ibus,
  input  logic [DataWidth-1:0] ULAResult,
  input  logic                 Flag_z,
  input  logic                 CarryOut,
  output logic [2:0]           ra1,
  output logic [2:0]           ra2,
  output logic [2:0]           ULAControl,
  output logic                 select_src,
  output logic [DataWidth-1:0] constante,
  output logic [2:0]           wa3,
  output logic [DataWidth-1:0] wd3,
  output logic                 we3,
  output logic                 done,
  output logic [DataWidth-1:0] result_q,
  output logic                 zero_q,
  output logic                 carry_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    T_LOADI = 2'b00,
    T_ALURR = 2'b01,
    T_ALURI = 2'b10,
    T_CMP   = 2'b11
  } itype_t;

  state_t                state_q, state_d;
  logic [InstrWidth-1:0] instr_q, instr_d;
  logic [DataWidth-1:0]  result_d;
  logic                  zero_d, carry_d;
  logic                  cmp_done_q, cmp_done_d;

  // Field views of the latched instruction; datapath outputs never look at ibus.instr.
  itype_t               f_type;
  logic [2:0]           f_op, f_rd, f_ra, f_rb;
  logic [DataWidth-1:0] f_imm;
  itype_t               in_type;
  logic                 accept;

  assign f_type  = itype_t'(instr_q[13+DataWidth:12+DataWidth]);
  assign f_op    = instr_q[11+DataWidth:9+DataWidth];
  assign f_rd    = instr_q[8+DataWidth:6+DataWidth];
  assign f_ra    = instr_q[5+DataWidth:3+DataWidth];
  assign f_rb    = instr_q[2+DataWidth:DataWidth];
  assign f_imm   = instr_q[DataWidth-1:0];
  assign in_type = itype_t'(ibus.instr[13+DataWidth:12+DataWidth]);

  assign ibus.instr_ready = reset && (state_q == S_IDLE);
  assign accept           = ibus.instr_valid && ibus.instr_ready;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    cmp_done_d = 1'b0;
    ra1        = 3'd0;
    ra2        = 3'd0;
    ULAControl = 3'd0;
    select_src = 1'b0;
    constante  = '0;
    wa3        = 3'd0;
    wd3        = '0;
    we3        = 1'b0;
    // CMP retires in the cycle after EXEC, when the FSM is already back in IDLE.
    done       = cmp_done_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          instr_d = ibus.instr;
          state_d = (in_type == T_LOADI) ? S_WB : S_EXEC;
        end
      end
      S_EXEC: begin
        ra1        = f_ra;
        ra2        = f_rb;
        ULAControl = f_op;
        if (f_type == T_ALURI) begin
          select_src = 1'b1;
          constante  = f_imm;
        end
        result_d = ULAResult;
        zero_d   = Flag_z;
        carry_d  = CarryOut;
        if (f_type == T_CMP) begin
          state_d    = S_IDLE;
          cmp_done_d = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        we3  = 1'b1;
        wa3  = f_rd;
        done = 1'b1;
        if (f_type == T_LOADI) begin
          wd3      = f_imm;
          result_d = f_imm;
        end else begin
          wd3 = result_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      cmp_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      cmp_done_q <= cmp_done_d;
    end
  end

endmodule
